// File: rtl/apb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : apb_pkg
//  Description : Shared definitions for the two-requester APB master front
//                end: FSM state encoding and default bus widths.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package apb_pkg;

    // Default widths for the request and APB data paths
    localparam int unsigned APB_ADDR_W = 32;
    localparam int unsigned APB_DATA_W = 32;

    // APB phase sequencer states; code 2'b11 is unused and recovers to IDLE
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        ACCESS = 2'b10
    } apb_state_e;

endpackage : apb_pkg
`default_nettype wire

// File: rtl/apb_req_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arb2
//  Description : Combinational two-way round-robin arbiter. A single eligible
//                requester always wins; with both eligible, the one that did
//                not win last time is granted.
//  Ports       : eligible_i    - per-requester eligibility
//                last_grant_i  - index of the most recently served requester
//                grant_valid_o - some requester is granted this cycle
//                grant_idx_o   - index of the granted requester
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2 (
    input  logic [1:0] eligible_i,
    input  logic       last_grant_i,
    output logic       grant_valid_o,
    output logic       grant_idx_o
);

    always_comb begin
        grant_valid_o = |eligible_i;
        grant_idx_o   = 1'b0;
        case (eligible_i)
            2'b01:   grant_idx_o = 1'b0;
            2'b10:   grant_idx_o = 1'b1;
            2'b11:   grant_idx_o = ~last_grant_i;
            default: grant_idx_o = 1'b0;
        endcase
    end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/apb_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : apb_req_arbiter
//  Description : Two-requester APB master front end. Arbitrates single-word
//                read/write requests round-robin, sequences the APB bus
//                through IDLE/SETUP/ACCESS, returns read data and status to
//                the winner, and aborts with an error when the slave stalls
//                for TIMEOUT ACCESS cycles (TIMEOUT=0 disables the abort).
//  Ports       : P_clk, P_rst          - clock, async active-low reset
//                rN_valid/write/addr/wdata - request from requester N
//                rN_done/err/rdata     - completion pulse, status, read data
//                P_addr/selx/enable/write/wdata - APB master outputs
//                P_ready/slverr/rdata  - APB slave responses
//  Revision    : 1.0 - initial release
// ============================================================================
module apb_req_arbiter
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_W  = APB_ADDR_W,
    parameter int unsigned DATA_W  = APB_DATA_W,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              P_clk,
    input  logic              P_rst,

    input  logic              r0_valid,
    input  logic              r0_write,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_done,
    output logic              r0_err,
    output logic [DATA_W-1:0] r0_rdata,

    input  logic              r1_valid,
    input  logic              r1_write,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_done,
    output logic              r1_err,
    output logic [DATA_W-1:0] r1_rdata,

    output logic [ADDR_W-1:0] P_addr,
    output logic              P_selx,
    output logic              P_enable,
    output logic              P_write,
    output logic [DATA_W-1:0] P_wdata,
    input  logic              P_ready,
    input  logic              P_slverr,
    input  logic [DATA_W-1:0] P_rdata
);

    // Counter only has to reach TIMEOUT-1
    localparam int unsigned c_cnt_w = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last =
        c_cnt_w'((TIMEOUT == 0) ? 0 : (TIMEOUT - 1));

    apb_state_e          state_q,  state_d;
    logic [ADDR_W-1:0]   addr_q,   addr_d;
    logic                write_q,  write_d;
    logic [DATA_W-1:0]   wdata_q,  wdata_d;
    logic                selx_q,   selx_d;
    logic                enable_q, enable_d;
    logic                grant_q,  grant_d;
    logic                last_q,   last_d;
    logic [c_cnt_w-1:0]  cnt_q,    cnt_d;
    logic [1:0]          done_q,   done_d;
    logic [1:0]          err_q,    err_d;
    logic [DATA_W-1:0]   rdata_q [2];
    logic [DATA_W-1:0]   rdata_d [2];

    logic [1:0]          w_eligible;
    logic                w_gnt_valid;
    logic                w_gnt_idx;
    logic                w_complete;
    logic                w_timeout;

    // A requester whose done pulse is out this cycle still shows its stale
    // valid; masking it keeps the same request from being granted twice.
    assign w_eligible = {r1_valid & ~done_q[1], r0_valid & ~done_q[0]};

    // Slave response is only sampled in a genuine ACCESS handshake
    assign w_complete = selx_q & enable_q & P_ready;
    assign w_timeout  = (TIMEOUT != 0) && (cnt_q == c_cnt_last);

    rr_arb2 u_rr_arb2 (
        .eligible_i    (w_eligible),
        .last_grant_i  (last_q),
        .grant_valid_o (w_gnt_valid),
        .grant_idx_o   (w_gnt_idx)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        write_d    = write_q;
        wdata_d    = wdata_q;
        selx_d     = selx_q;
        enable_d   = enable_q;
        grant_d    = grant_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        done_d     = 2'b00;
        err_d      = err_q;
        rdata_d[0] = rdata_q[0];
        rdata_d[1] = rdata_q[1];

        case (state_q)
            IDLE: begin
                selx_d   = 1'b0;
                enable_d = 1'b0;
                if (w_gnt_valid) begin
                    grant_d = w_gnt_idx;
                    addr_d  = w_gnt_idx ? r1_addr  : r0_addr;
                    write_d = w_gnt_idx ? r1_write : r0_write;
                    wdata_d = w_gnt_idx ? r1_wdata : r0_wdata;
                    selx_d  = 1'b1;
                    state_d = SETUP;
                end
            end

            SETUP: begin
                enable_d = 1'b1;
                cnt_d    = '0;
                state_d  = ACCESS;
            end

            ACCESS: begin
                if (w_complete) begin
                    selx_d          = 1'b0;
                    enable_d        = 1'b0;
                    state_d         = IDLE;
                    done_d[grant_q] = 1'b1;
                    err_d[grant_q]  = P_slverr;
                    if (!write_q) begin
                        rdata_d[grant_q] = P_rdata;
                    end
                    last_d          = grant_q;
                end else if (w_timeout) begin
                    selx_d           = 1'b0;
                    enable_d         = 1'b0;
                    state_d          = IDLE;
                    done_d[grant_q]  = 1'b1;
                    err_d[grant_q]   = 1'b1;
                    rdata_d[grant_q] = '0;
                    last_d           = grant_q;
                end else begin
                    cnt_d = cnt_q + c_cnt_w'(1);
                end
            end

            default: begin
                selx_d   = 1'b0;
                enable_d = 1'b0;
                state_d  = IDLE;
            end
        endcase
    end

    always_ff @(posedge P_clk or negedge P_rst) begin
        if (!P_rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            write_q    <= 1'b0;
            wdata_q    <= '0;
            selx_q     <= 1'b0;
            enable_q   <= 1'b0;
            grant_q    <= 1'b0;
            last_q     <= 1'b1;   // requester 0 wins the first contention
            cnt_q      <= '0;
            done_q     <= 2'b00;
            err_q      <= 2'b00;
            rdata_q[0] <= '0;
            rdata_q[1] <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            write_q    <= write_d;
            wdata_q    <= wdata_d;
            selx_q     <= selx_d;
            enable_q   <= enable_d;
            grant_q    <= grant_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
            err_q      <= err_d;
            rdata_q[0] <= rdata_d[0];
            rdata_q[1] <= rdata_d[1];
        end
    end

    assign P_addr   = addr_q;
    assign P_selx   = selx_q;
    assign P_enable = enable_q;
    assign P_write  = write_q;
    assign P_wdata  = wdata_q;

    assign r0_done  = done_q[0];
    assign r0_err   = err_q[0];
    assign r0_rdata = rdata_q[0];
    assign r1_done  = done_q[1];
    assign r1_err   = err_q[1];
    assign r1_rdata = rdata_q[1];

endmodule : apb_req_arbiter
`default_nettype wire

// File: tb/tb_apb_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_apb_req_arbiter
//  Description : Self-checking bench for apb_req_arbiter. Expected bus phases
//                and completions are queued when requests are issued and
//                compared when the DUT shows them on the bus / done outputs.
//  Ports       : none
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_req_arbiter;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    always #5 clk = ~clk;

    logic        r0_valid, r0_write, r0_done, r0_err;
    logic [31:0] r0_addr, r0_wdata, r0_rdata;
    logic        r1_valid, r1_write, r1_done, r1_err;
    logic [31:0] r1_addr, r1_wdata, r1_rdata;
    logic [31:0] P_addr, P_wdata, P_rdata;
    logic        P_selx, P_enable, P_write, P_ready, P_slverr;

    apb_req_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .P_clk    (clk),
        .P_rst    (rst_n),
        .r0_valid (r0_valid),
        .r0_write (r0_write),
        .r0_addr  (r0_addr),
        .r0_wdata (r0_wdata),
        .r0_done  (r0_done),
        .r0_err   (r0_err),
        .r0_rdata (r0_rdata),
        .r1_valid (r1_valid),
        .r1_write (r1_write),
        .r1_addr  (r1_addr),
        .r1_wdata (r1_wdata),
        .r1_done  (r1_done),
        .r1_err   (r1_err),
        .r1_rdata (r1_rdata),
        .P_addr   (P_addr),
        .P_selx   (P_selx),
        .P_enable (P_enable),
        .P_write  (P_write),
        .P_wdata  (P_wdata),
        .P_ready  (P_ready),
        .P_slverr (P_slverr),
        .P_rdata  (P_rdata)
    );

    // ---------------- slave model ----------------
    int          wait_cfg;
    bit          err_cfg;
    bit          hang;
    logic [31:0] rdata_cfg;
    int          acc_cnt;

    assign P_ready  = P_selx & P_enable & ~hang & (acc_cnt == wait_cfg);
    assign P_slverr = err_cfg;
    assign P_rdata  = rdata_cfg;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          acc_cnt <= 0;
        else if (P_selx & P_enable & ~P_ready) acc_cnt <= acc_cnt + 1;
        else                                 acc_cnt <= 0;
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        int          idx;
        bit          err;
        logic [31:0] rdata;
        int          acc;
    } cmp_t;

    typedef struct {
        logic [31:0] addr;
        bit          wr;
        logic [31:0] wdata;
    } bus_t;

    cmp_t        exp_q[$];
    bus_t        bus_q[$];
    logic [31:0] model_rd [2];

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Queue the expected bus phase and completion for one request, using the
    // slave configuration in force when the request is issued.
    task automatic expect_xfer(input int idx, input bit wr,
                               input logic [31:0] addr, input logic [31:0] wdata);
        bus_t b;
        cmp_t c;
        b.addr  = addr;
        b.wr    = wr;
        b.wdata = wdata;
        bus_q.push_back(b);
        c.idx = idx;
        if (hang) begin
            c.err   = 1'b1;
            c.rdata = 32'h0;
            c.acc   = TO;
        end else begin
            c.err   = err_cfg;
            c.rdata = wr ? model_rd[idx] : rdata_cfg;
            c.acc   = wait_cfg + 1;
        end
        model_rd[idx] = c.rdata;
        exp_q.push_back(c);
    endtask

    // Present a request, hold it until done, drop valid the cycle after done.
    task automatic issue(input int idx, input bit wr,
                         input logic [31:0] addr, input logic [31:0] wdata);
        bit seen;
        if (idx == 0) begin
            r0_write = wr; r0_addr = addr; r0_wdata = wdata; r0_valid = 1'b1;
        end else begin
            r1_write = wr; r1_addr = addr; r1_wdata = wdata; r1_valid = 1'b1;
        end
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(posedge clk); #1;
            seen = (idx == 0) ? r0_done : r1_done;
        end
        if (!seen) chk("done_wait_timeout", 0, 1);
        @(posedge clk); #1;
        if (idx == 0) r0_valid = 1'b0;
        else          r1_valid = 1'b0;
    endtask

    // ---------------- bus / completion monitor ----------------
    initial begin
        int          acc_obs;
        logic [31:0] setup_addr;
        bus_t        b;
        cmp_t        c;
        int          d;
        acc_obs    = 0;
        setup_addr = 32'h0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (P_selx && !P_enable) begin
                    acc_obs = 0;
                    if (bus_q.size() == 0) begin
                        chk("setup_unexpected", 1, 0);
                    end else begin
                        b = bus_q.pop_front();
                        setup_addr = b.addr;
                        chk("setup_addr",  P_addr,  b.addr);
                        chk("setup_write", P_write, b.wr);
                        chk("setup_wdata", P_wdata, b.wdata);
                    end
                end
                if (P_selx && P_enable) begin
                    acc_obs++;
                    chk("access_addr_stable", P_addr, setup_addr);
                end
                if (r0_done || r1_done) begin
                    chk("single_done", r0_done & r1_done, 0);
                    if (exp_q.size() == 0) begin
                        chk("done_unexpected", 1, 0);
                    end else begin
                        c = exp_q.pop_front();
                        d = r1_done ? 1 : 0;
                        chk("done_idx",      d, c.idx);
                        chk("done_err",      d ? r1_err : r0_err, c.err);
                        chk("done_rdata",    d ? r1_rdata : r0_rdata, c.rdata);
                        chk("access_cycles", acc_obs, c.acc);
                        chk("bus_idle_on_done", {P_selx, P_enable}, 0);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        r0_valid = 0; r0_write = 0; r0_addr = 0; r0_wdata = 0;
        r1_valid = 0; r1_write = 0; r1_addr = 0; r1_wdata = 0;
        wait_cfg = 0; err_cfg = 0; hang = 0; rdata_cfg = 32'h0;
        model_rd[0] = 32'h0;
        model_rd[1] = 32'h0;

        repeat (2) @(negedge clk);
        chk("rst_selx",   P_selx,   0);
        chk("rst_enable", P_enable, 0);
        chk("rst_addr",   P_addr,   0);
        chk("rst_done",   {r0_done, r1_done}, 0);
        chk("rst_err",    {r0_err, r1_err},   0);

        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Zero-wait write from requester 0; rdata must hold (P_rdata is noise)
        wait_cfg = 0; rdata_cfg = 32'h55AA55AA;
        expect_xfer(0, 1'b1, 32'h04, 32'hDEADBEEF);
        issue(0, 1'b1, 32'h04, 32'hDEADBEEF);

        // Read with 2 wait states from requester 1
        wait_cfg = 2; rdata_cfg = 32'h12345678;
        expect_xfer(1, 1'b0, 32'h08, 32'h0);
        issue(1, 1'b0, 32'h08, 32'h0);

        // Contention twice: r0 then r1 each round
        wait_cfg = 1; rdata_cfg = 32'hCAFE0001;
        repeat (2) begin
            expect_xfer(0, 1'b0, 32'h10, 32'h0);
            expect_xfer(1, 1'b1, 32'h14, 32'hA5A5A5A5);
            fork
                issue(0, 1'b0, 32'h10, 32'h0);
                issue(1, 1'b1, 32'h14, 32'hA5A5A5A5);
            join
        end

        // Slave error on a read
        wait_cfg = 0; err_cfg = 1'b1; rdata_cfg = 32'h0BAD0BAD;
        expect_xfer(0, 1'b0, 32'h20, 32'h0);
        issue(0, 1'b0, 32'h20, 32'h0);
        err_cfg = 1'b0;

        // Timeout: slave never ready
        hang = 1'b1;
        expect_xfer(0, 1'b0, 32'h24, 32'h0);
        issue(0, 1'b0, 32'h24, 32'h0);

        // Reset in the middle of ACCESS for a requester 1 write
        begin
            bus_t b;
            bit   in_access;
            b.addr = 32'h28; b.wr = 1'b1; b.wdata = 32'h600D600D;
            bus_q.push_back(b);
            r1_write = 1'b1; r1_addr = 32'h28; r1_wdata = 32'h600D600D; r1_valid = 1'b1;
            in_access = 1'b0;
            for (int i = 0; i < 20 && !in_access; i++) begin
                @(posedge clk); #1;
                in_access = P_enable;
            end
            if (!in_access) chk("reach_access", 0, 1);
            @(posedge clk); #3;
            rst_n = 1'b0;
            #1;
            chk("arst_selx",   P_selx,   0);
            chk("arst_enable", P_enable, 0);
            chk("arst_addr",   P_addr,   0);
            chk("arst_wdata",  P_wdata,  0);
            chk("arst_write",  P_write,  0);
            chk("arst_outs",   {r0_done, r1_done, r0_err, r1_err}, 0);
            chk("arst_rdata",  {r0_rdata, r1_rdata}, 0);
            r1_valid = 1'b0;
            model_rd[0] = 32'h0;
            model_rd[1] = 32'h0;
            hang = 1'b0;
            @(posedge clk); #1;
            rst_n = 1'b1;
            @(posedge clk); #1;
        end

        // After reset requester 0 must win contention again
        wait_cfg = 0; rdata_cfg = 32'h77776666;
        expect_xfer(0, 1'b0, 32'h30, 32'h0);
        expect_xfer(1, 1'b0, 32'h34, 32'h0);
        fork
            issue(0, 1'b0, 32'h30, 32'h0);
            issue(1, 1'b0, 32'h34, 32'h0);
        join

        repeat (3) @(posedge clk);
        #1;
        chk("sb_completions_left", exp_q.size(), 0);
        chk("sb_bus_left",         bus_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_apb_req_arbiter
`default_nettype wire
